beam_sum: RTL and testbench
===========================

BEAM_SUM -- requirements
Module: beam_sum

Interface
REQ-001 SHALL have parameter GAIN_SHIFT, default 3, arithmetic right-shift applied to the accumulated sum (legal 0..3).
REQ-002 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: sample_valid  in  1  one-cycle strobe; all eight delayed_pcm_data_N are valid.
REQ-005 SHALL have ports: delayed_pcm_data_0..delayed_pcm_data_7  in  19 each  signed two's-complement per-mic PCM from the delay stage.
REQ-006 SHALL have ports: chan_enable  in  8  bit N includes mic N in the sum; sampled with sample_valid.
REQ-007 SHALL have ports: sum_out  out  19  signed beamformed sample.
REQ-008 SHALL have ports: sum_valid  out  1  sum_out valid; held until accepted.
REQ-009 SHALL have ports: sum_ready  in  1  downstream accepts when sum_valid and sum_ready are high on the same edge.
REQ-010 SHALL have ports: busy  out  1  high in any state other than IDLE.
REQ-011 SHALL have ports: overrun  out  1  one-cycle pulse when a sample_valid is dropped.

Function
REQ-012 SHALL implement FSM IDLE -> ACCUM -> NORM -> HOLD -> IDLE.
REQ-013 IDLE with sample_valid SHALL capture all eight inputs and chan_enable into registers, clear the 22-bit accumulator and index, and enter ACCUM.
REQ-014 ACCUM SHALL add one channel per cycle, index 0..7, sign-extended to 22 bits, only when its captured enable bit is 1; it SHALL enter NORM after index 7.
REQ-015 NORM SHALL load sum_out with accumulator >>> GAIN_SHIFT, arithmetic with truncation toward minus infinity, then enter HOLD with sum_valid=1.
REQ-016 Latency SHALL be fixed: sum_valid rises 10 edges after the capture edge (1 capture, 8 accumulate, 1 normalise).
REQ-017 HOLD SHALL keep sum_out and sum_valid stable until the handshake edge; at that edge it SHALL drop sum_valid and go to IDLE.
REQ-018 When sample_valid coincides with the handshake edge in HOLD, the block SHALL capture the new sample and go directly to ACCUM, with no drop and no overrun.
REQ-019 A sample_valid in ACCUM, NORM, or in HOLD without handshake SHALL be ignored and SHALL pulse overrun for exactly one cycle.
REQ-020 chan_enable = 8'h00 SHALL produce sum_out = 0 with normal latency and handshake.
REQ-021 Input changes after the capture edge SHALL NOT affect the sample in flight.

Reset
REQ-022 rst low SHALL, asynchronously, force state IDLE, sum_out=0, sum_valid=0, busy=0, overrun=0, accumulator=0 and index=0, including mid-ACCUM or mid-HOLD; the in-flight sample is discarded.
REQ-023 The first capture after rst deasserts SHALL be the first sample_valid seen on a rising edge with rst high.

Configuration
REQ-024 Macro BEAM_SUM_SAT_EN defined: the NORM result SHALL saturate to [-262144, +262143] when it falls outside 19-bit signed range.
REQ-025 Macro BEAM_SUM_SAT_EN undefined: the NORM result SHALL be the low 19 bits (wrap); with GAIN_SHIFT=3 both builds are identical.

Structure
REQ-026 Shared package beam_pkg SHALL hold PCM_W=19, N_MICS=8, ACC_W=22 and the FSM state enum; the delay stage SHALL reuse PCM_W and N_MICS.
REQ-027 Normalisation SHALL be one sub-module, beam_norm (shift plus optional saturation, combinational), instanced once.

Verification
REQ-028 All channels = 1000, enable=8'hFF, GAIN_SHIFT=3, sum_ready=1 -> sum_out=1000, sum_valid rises exactly 10 edges after the strobe.
REQ-029 Channels alternating +5000/-5000, enable=8'h0F -> sum_out=0; enable=8'h00 with any data -> sum_out=0.
REQ-030 GAIN_SHIFT=0, all channels = +262143, enable=8'hFF -> with BEAM_SUM_SAT_EN sum_out=262143; without it sum_out = low 19 bits of 2097144 (-8).
REQ-031 sum_ready=0 for 20 cycles, second sample_valid at cycle 5 of HOLD -> overrun pulses once, sum_out unchanged; a strobe on the handshake edge -> accepted, no overrun.
REQ-032 rst asserted at ACCUM index 4 -> all outputs 0 within the same cycle; next sample processes cleanly with the correct sum.

Source files
------------

// File: rtl/beam_pkg.sv
// rtl/beam_pkg.sv - shared widths, FSM state type and sign-extension helper for the beam summer.
package beam_pkg;

   localparam int PCM_W  = 19;
   localparam int N_MICS = 8;
   localparam int ACC_W  = 22;
   localparam int IDX_W  = $clog2(N_MICS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_NORM  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   function automatic logic signed [ACC_W-1:0] sext_pcm(input logic signed [PCM_W-1:0] x);
      return {{(ACC_W-PCM_W){x[PCM_W-1]}}, x};
   endfunction

endpackage

// File: rtl/beam_norm.sv
// rtl/beam_norm.sv - combinational gain shift of the accumulator; BEAM_SUM_SAT_EN selects saturation over wrap.
module beam_norm
   import beam_pkg::*;
#(
   parameter int unsigned GAIN_SHIFT = 3
) (
   input  logic signed [ACC_W-1:0] acc_i,
   output logic signed [PCM_W-1:0] norm_o
);

   logic signed [ACC_W-1:0] shifted;
   assign shifted = acc_i >>> GAIN_SHIFT;

`ifdef BEAM_SUM_SAT_EN
   localparam logic signed [ACC_W-1:0] PCM_MAX = ACC_W'((1 << (PCM_W-1)) - 1);
   localparam logic signed [ACC_W-1:0] PCM_MIN = -ACC_W'(1 << (PCM_W-1));

   always_comb begin
      norm_o = shifted[PCM_W-1:0];
      if (shifted > PCM_MAX)
         norm_o = PCM_MAX[PCM_W-1:0];
      else if (shifted < PCM_MIN)
         norm_o = PCM_MIN[PCM_W-1:0];
   end
`else
   // Out-of-range results keep only the low PCM_W bits.
   logic unused_hi;
   assign unused_hi = ^shifted[ACC_W-1:PCM_W];
   assign norm_o    = shifted[PCM_W-1:0];
`endif

endmodule

// File: rtl/beam_sum.sv
// rtl/beam_sum.sv - eight-mic delay-and-sum beamformer back end: capture, serial accumulate, normalise, hold.
// Saturating normalisation is selected with BEAM_SUM_SAT_EN.
module beam_sum
   import beam_pkg::*;
#(
   parameter int unsigned GAIN_SHIFT = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sample_valid,
   input  logic signed [PCM_W-1:0] delayed_pcm_data_0,
   input  logic signed [PCM_W-1:0] delayed_pcm_data_1,
   input  logic signed [PCM_W-1:0] delayed_pcm_data_2,
   input  logic signed [PCM_W-1:0] delayed_pcm_data_3,
   input  logic signed [PCM_W-1:0] delayed_pcm_data_4,
   input  logic signed [PCM_W-1:0] delayed_pcm_data_5,
   input  logic signed [PCM_W-1:0] delayed_pcm_data_6,
   input  logic signed [PCM_W-1:0] delayed_pcm_data_7,
   input  logic [N_MICS-1:0]       chan_enable,
   output logic signed [PCM_W-1:0] sum_out,
   output logic                    sum_valid,
   input  logic                    sum_ready,
   output logic                    busy,
   output logic                    overrun
);

   logic signed [PCM_W-1:0] din [N_MICS];
   assign din[0] = delayed_pcm_data_0;
   assign din[1] = delayed_pcm_data_1;
   assign din[2] = delayed_pcm_data_2;
   assign din[3] = delayed_pcm_data_3;
   assign din[4] = delayed_pcm_data_4;
   assign din[5] = delayed_pcm_data_5;
   assign din[6] = delayed_pcm_data_6;
   assign din[7] = delayed_pcm_data_7;

   state_t                  state_q;
   logic [IDX_W-1:0]        idx_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [PCM_W-1:0] data_q [N_MICS];
   logic [N_MICS-1:0]       en_q;
   logic signed [PCM_W-1:0] sum_out_q;
   logic                    sum_valid_q;
   logic                    busy_q;
   logic                    overrun_q;
   logic signed [PCM_W-1:0] norm_out;

   beam_norm #(.GAIN_SHIFT(GAIN_SHIFT)) u_norm (
      .acc_i  (acc_q),
      .norm_o (norm_out)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         en_q        <= '0;
         sum_out_q   <= '0;
         sum_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         for (int i = 0; i < N_MICS; i++) data_q[i] <= '0;
      end else begin
         overrun_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (sample_valid) begin
                  for (int i = 0; i < N_MICS; i++) data_q[i] <= din[i];
                  en_q    <= chan_enable;
                  acc_q   <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (en_q[idx_q])
                  acc_q <= acc_q + sext_pcm(data_q[idx_q]);
               idx_q <= idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(N_MICS-1))
                  state_q <= ST_NORM;
               if (sample_valid)
                  overrun_q <= 1'b1;
            end
            ST_NORM: begin
               sum_out_q   <= norm_out;
               sum_valid_q <= 1'b1;
               state_q     <= ST_HOLD;
               if (sample_valid)
                  overrun_q <= 1'b1;
            end
            ST_HOLD: begin
               if (sum_ready) begin
                  sum_valid_q <= 1'b0;
                  // A strobe on the handshake edge starts the next sample without a gap.
                  if (sample_valid) begin
                     for (int i = 0; i < N_MICS; i++) data_q[i] <= din[i];
                     en_q    <= chan_enable;
                     acc_q   <= '0;
                     idx_q   <= '0;
                     state_q <= ST_ACCUM;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end else if (sample_valid) begin
                  overrun_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sum_out   = sum_out_q;
   assign sum_valid = sum_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_beam_sum.sv
// tb/tb_beam_sum.sv - directed self-checking bench for beam_sum (GAIN_SHIFT 3 and 0 instances).
module tb_beam_sum;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                sample_valid = 1'b0;
   logic signed [18:0]  pcm [8];
   logic [7:0]          chan_enable = 8'h00;
   logic                sum_ready = 1'b1;
   logic signed [18:0]  sum_out, sum_out0;
   logic                sum_valid, sum_valid0;
   logic                busy, busy0;
   logic                overrun, overrun0;

   int checks = 0;
   int failures = 0;
   int lat, ovr, cnt;

   always #5 clk = ~clk;

   beam_sum #(.GAIN_SHIFT(3)) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid),
      .delayed_pcm_data_0(pcm[0]), .delayed_pcm_data_1(pcm[1]),
      .delayed_pcm_data_2(pcm[2]), .delayed_pcm_data_3(pcm[3]),
      .delayed_pcm_data_4(pcm[4]), .delayed_pcm_data_5(pcm[5]),
      .delayed_pcm_data_6(pcm[6]), .delayed_pcm_data_7(pcm[7]),
      .chan_enable(chan_enable), .sum_out(sum_out), .sum_valid(sum_valid),
      .sum_ready(sum_ready), .busy(busy), .overrun(overrun)
   );

   beam_sum #(.GAIN_SHIFT(0)) dut0 (
      .clk(clk), .rst(rst), .sample_valid(sample_valid),
      .delayed_pcm_data_0(pcm[0]), .delayed_pcm_data_1(pcm[1]),
      .delayed_pcm_data_2(pcm[2]), .delayed_pcm_data_3(pcm[3]),
      .delayed_pcm_data_4(pcm[4]), .delayed_pcm_data_5(pcm[5]),
      .delayed_pcm_data_6(pcm[6]), .delayed_pcm_data_7(pcm[7]),
      .chan_enable(chan_enable), .sum_out(sum_out0), .sum_valid(sum_valid0),
      .sum_ready(sum_ready), .busy(busy0), .overrun(overrun0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_all(input int v);
      for (int i = 0; i < 8; i++) pcm[i] = 19'(v);
   endtask

   // Strobe one sample, scramble inputs after capture, optionally strobe again
   // before edge strobe_at+1, and wait (bounded) for sum_valid.
   task automatic send(input logic [7:0] en, input int strobe_at, output int l, output int o);
      chan_enable  = en;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      for (int i = 0; i < 8; i++) pcm[i] = 19'($urandom);
      chan_enable = ~en;
      l = 1;
      o = 0;
      while (!sum_valid && l < 30) begin
         if (l == strobe_at) sample_valid = 1'b1;
         step();
         sample_valid = 1'b0;
         if (overrun) o++;
         l++;
      end
   endtask

   initial begin
      set_all(0);
      repeat (3) step();
      chk("reset_sum_out", sum_out, 0);
      chk("reset_sum_valid", sum_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_overrun", overrun, 0);
      rst = 1'b1;
      step();

      // All 1000, all enabled.
      set_all(1000);
      send(8'hFF, 0, lat, ovr);
      chk("basic_latency", lat, 10);
      chk("basic_sum", sum_out, 1000);
      chk("basic_sum_g0", sum_out0, 8000);
      chk("basic_busy", busy, 1);
      step();
      chk("basic_handshake_valid", sum_valid, 0);
      chk("basic_handshake_busy", busy, 0);

      // Alternating +/-5000, lower four enabled, with inputs scrambled after capture.
      for (int i = 0; i < 8; i++) pcm[i] = (i % 2 == 0) ? 19'sd5000 : -19'sd5000;
      pcm[4] = 19'sd100000;
      send(8'h0F, 0, lat, ovr);
      chk("alt_latency", lat, 10);
      chk("alt_sum", sum_out, 0);
      chk("alt_sum_g0", sum_out0, 0);
      step();

      // No channels enabled; strobe during ACCUM is dropped with one overrun pulse.
      set_all(1234);
      send(8'h00, 3, lat, ovr);
      chk("zero_en_latency", lat, 10);
      chk("zero_en_sum", sum_out, 0);
      chk("zero_en_sum_g0", sum_out0, 0);
      chk("accum_overrun_pulses", ovr, 1);
      step();

      // Floor on negative shift.
      set_all(0);
      pcm[0] = -19'sd1;
      send(8'h01, 0, lat, ovr);
      chk("neg_floor", sum_out, -1);
      chk("neg_floor_g0", sum_out0, -1);
      step();
      pcm[0] = 19'sd7;
      send(8'h01, 0, lat, ovr);
      chk("pos_floor", sum_out, 0);
      chk("pos_floor_g0", sum_out0, 7);
      step();

      // Full-scale positive and negative.
      set_all(262143);
      send(8'hFF, 0, lat, ovr);
      chk("fs_pos", sum_out, 262143);
`ifdef BEAM_SUM_SAT_EN
      chk("fs_pos_g0", sum_out0, 262143);
`else
      chk("fs_pos_g0", sum_out0, -8);
`endif
      step();
      set_all(-262144);
      send(8'hFF, 0, lat, ovr);
      chk("fs_neg", sum_out, -262144);
`ifdef BEAM_SUM_SAT_EN
      chk("fs_neg_g0", sum_out0, -262144);
`else
      chk("fs_neg_g0", sum_out0, 0);
`endif
      step();

      // Backpressure: 20 cycles in HOLD, stray strobe at cycle 5.
      set_all(1000);
      sum_ready = 1'b0;
      send(8'hFF, 0, lat, ovr);
      chk("bp_latency", lat, 10);
      cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 5) set_all(2000);
         sample_valid = (c == 5);
         step();
         sample_valid = 1'b0;
         if (overrun) cnt++;
      end
      chk("bp_overrun_pulses", cnt, 1);
      chk("bp_sum_held", sum_out, 1000);
      chk("bp_valid_held", sum_valid, 1);

      // Strobe on the handshake edge is accepted immediately.
      set_all(3000);
      chan_enable  = 8'hFF;
      sum_ready    = 1'b1;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      chk("hs_strobe_overrun", overrun, 0);
      chk("hs_strobe_valid", sum_valid, 0);
      chk("hs_strobe_busy", busy, 1);
      set_all(-55);
      lat = 1;
      while (!sum_valid && lat < 30) begin
         step();
         lat++;
      end
      chk("hs_latency", lat, 10);
      chk("hs_sum", sum_out, 3000);
      step();

      // Reset at ACCUM index 4, then a clean sample.
      set_all(500);
      chan_enable  = 8'hFF;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      repeat (4) step();
      #1 rst = 1'b0;
      #1;
      chk("midrst_sum_out", sum_out, 0);
      chk("midrst_valid", sum_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_overrun", overrun, 0);
      #1 rst = 1'b1;
      step();
      chk("post_rst_idle", busy, 0);
      for (int i = 0; i < 8; i++) pcm[i] = 19'(100 * (i + 1));
      send(8'hA5, 0, lat, ovr);
      chk("post_rst_latency", lat, 10);
      chk("post_rst_sum", sum_out, 225);
      chk("post_rst_sum_g0", sum_out0, 1800);
      step();
      chk("post_rst_done", sum_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
